ysyx_25020037_wbu_q: RTL and testbench

Parametrised writeback stage with a DEPTH-entry in-order retire queue between LSU and the GPR/CSR commit logic. LSU results are accepted on a valid/ready handshake. The block selects the writeback value (CSR read data or processed load/ALU data) and presents the GPR write port and trap events at the queue head. Retirement is gated by a downstream ready, and a 64-bit retired-instruction counter is maintained. It replaces the single-register, always-accept writeback stage and lets the LSU stall instead of dropping results.

---
 rtl/ysyx_25020037_wbu_q.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_25020037_wbu_q.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_wbu_q.sv
// ---------------------------------------------------------------------------
// ysyx_25020037_wbu_q
//
// Writeback stage with a DEPTH-entry in-order retire queue sitting between
// the LSU and the GPR/CSR commit logic.
//
// Flow:
//   - LSU results enter on a valid/ready handshake (in_valid/in_ready).
//   - The GPR writeback value (CSR read data or load/ALU result) is chosen
//     at enqueue. A CSR value is therefore never re-read after acceptance.
//   - The queue head is presented on the commit_* / rf_* / csr_* / trap_*
//     outputs.
//   - The head retires when commit_valid & commit_ready.
//   - A 64-bit retired-instruction counter (instret) counts retirements.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   LSU handshake
//   in_pc .. in_mret    instruction payload from the LSU
//   flush               discard every queued entry (the head may still retire)
//   commit_ready        downstream accepts the head this cycle
//   commit_valid        head entry present
//   commit_pc           head pc (pc[XLEN-1:2])
//   rf_we/waddr/wdata   GPR write port, strobed on retire
//   csr_we/csr_wdata    CSR write port, strobed on retire
//   trap_ecall/mret     trap events, strobed on retire
//   instret             retired instruction count, wraps modulo 2^64
// ---------------------------------------------------------------------------
module ysyx_25020037_wbu_q #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 30,
    parameter int RIDX_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_gpr_we,
    input  logic              in_load_we,
    input  logic              in_csr_sel,
    input  logic [XLEN-1:0]   in_csr_rdata,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic              in_csr_we,
    input  logic [XLEN-1:0]   in_csr_wdata,
    input  logic              in_ecall,
    input  logic              in_mret,
    input  logic              flush,
    input  logic              commit_ready,
    output logic              commit_valid,
    output logic [PC_W-1:0]   commit_pc,
    output logic              rf_we,
    output logic [RIDX_W-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              csr_we,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              trap_ecall,
    output logic              trap_mret,
    output logic [63:0]       instret
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Payload storage: deliberately not reset, because validity is tracked
    // solely by count_r.
    logic [PC_W-1:0]   pc_mem_r        [DEPTH];
    logic [RIDX_W-1:0] rd_mem_r        [DEPTH];
    logic              gpr_we_mem_r    [DEPTH];
    logic [XLEN-1:0]   wb_data_mem_r   [DEPTH];
    logic              csr_we_mem_r    [DEPTH];
    logic [XLEN-1:0]   csr_wdata_mem_r [DEPTH];
    logic              ecall_mem_r     [DEPTH];
    logic              mret_mem_r      [DEPTH];

    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [63:0]      instret_r;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             retire_s;
    logic             commit_valid_s;
    logic [XLEN-1:0]  wb_data_s;

    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Reset also masks the head, so a reset arriving mid-operation never
    // leaks a strobe while the (synchronous) reset is still pending.
    assign commit_valid_s = ~empty_s & ~rst;
    assign retire_s       = commit_valid_s & commit_ready;

    // No ready-through-dequeue: a full queue refuses input even when the
    // head retires in the same cycle.
    assign in_ready = ~full_s & ~rst & ~flush;
    assign push_s   = in_valid & in_ready;

    // Writeback data mux applied at enqueue time.
    always_comb begin
        wb_data_s = in_wdata;
        if (in_csr_sel) begin
            wb_data_s = in_csr_rdata;
        end else begin
            wb_data_s = in_wdata;
        end
    end

    // Payload write at the tail slot on an accepted handshake.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]        <= in_pc;
            rd_mem_r[wr_ptr_r]        <= in_rd;
            gpr_we_mem_r[wr_ptr_r]    <= in_gpr_we | in_load_we;
            wb_data_mem_r[wr_ptr_r]   <= wb_data_s;
            csr_we_mem_r[wr_ptr_r]    <= in_csr_we;
            csr_wdata_mem_r[wr_ptr_r] <= in_csr_wdata;
            ecall_mem_r[wr_ptr_r]     <= in_ecall;
            mret_mem_r[wr_ptr_r]      <= in_mret;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            // DEPTH is a power of two, so the natural PTR_W-bit roll-over
            // is the wrap from DEPTH-1 back to 0.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (retire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, retire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Retired-instruction counter; a retire during flush still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= 64'd0;
        end else if (retire_s) begin
            instret_r <= instret_r + 64'd1;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign commit_valid = commit_valid_s;
    assign commit_pc    = pc_mem_r[rd_ptr_r];
    assign rf_we        = retire_s & gpr_we_mem_r[rd_ptr_r]
                          & (rd_mem_r[rd_ptr_r] != {RIDX_W{1'b0}});
    assign rf_waddr     = rd_mem_r[rd_ptr_r];
    assign rf_wdata     = wb_data_mem_r[rd_ptr_r];
    assign csr_we       = retire_s & csr_we_mem_r[rd_ptr_r];
    assign csr_wdata    = csr_wdata_mem_r[rd_ptr_r];
    assign trap_ecall   = retire_s & ecall_mem_r[rd_ptr_r];
    assign trap_mret    = retire_s & mret_mem_r[rd_ptr_r];
    assign instret      = instret_r;

endmodule

// File: tb/tb_ysyx_25020037_wbu_q.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25020037_wbu_q
//
// Bench for the writeback retire queue.
// - Single-entry transactions come from a table of hand-computed records.
// - The multi-cycle cases are written out as directed sequences: back-pressure
//   when full, a steady stream with pointer wrap, flush, instret wrap and
//   reset mid-operation.
// - Inputs change 1 ns after posedge; outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_ysyx_25020037_wbu_q;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_pc;
    logic [3:0]  in_rd;
    logic        in_gpr_we;
    logic        in_load_we;
    logic        in_csr_sel;
    logic [31:0] in_csr_rdata;
    logic [31:0] in_wdata;
    logic        in_csr_we;
    logic [31:0] in_csr_wdata;
    logic        in_ecall;
    logic        in_mret;
    logic        flush;
    logic        commit_ready;
    logic        commit_valid;
    logic [29:0] commit_pc;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        trap_ecall;
    logic        trap_mret;
    logic [63:0] instret;

    ysyx_25020037_wbu_q #(
        .XLEN(32), .PC_W(30), .RIDX_W(4), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rd(in_rd),
        .in_gpr_we(in_gpr_we), .in_load_we(in_load_we),
        .in_csr_sel(in_csr_sel), .in_csr_rdata(in_csr_rdata),
        .in_wdata(in_wdata), .in_csr_we(in_csr_we),
        .in_csr_wdata(in_csr_wdata), .in_ecall(in_ecall), .in_mret(in_mret),
        .flush(flush), .commit_ready(commit_ready),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_wdata(csr_wdata),
        .trap_ecall(trap_ecall), .trap_mret(trap_mret),
        .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] pc;
        logic [3:0]  rd;
        logic        gpr_we;
        logic        load_we;
        logic        csr_sel;
        logic [31:0] csr_rdata;
        logic [31:0] wdata;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic        ecall;
        logic        mret;
        logic        e_rf_we;
        logic [31:0] e_wdata;
        logic        e_csr_we;
        logic        e_ecall;
        logic        e_mret;
    } vec_t;

    vec_t        vecs[8];
    int          n_checks;
    int          n_fail;
    logic [63:0] exp_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic clr_inputs();
        in_valid     = 1'b0;
        in_pc        = 30'h0;
        in_rd        = 4'h0;
        in_gpr_we    = 1'b0;
        in_load_we   = 1'b0;
        in_csr_sel   = 1'b0;
        in_csr_rdata = 32'h0;
        in_wdata     = 32'h0;
        in_csr_we    = 1'b0;
        in_csr_wdata = 32'h0;
        in_ecall     = 1'b0;
        in_mret      = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_inputs();
        commit_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_instret = 64'd0;
    endtask

    task automatic push_alu(input logic [29:0] pc, input logic [3:0] rd, input logic [31:0] d);
        in_valid  = 1'b1;
        in_pc     = pc;
        in_rd     = rd;
        in_gpr_we = 1'b1;
        in_wdata  = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //            pc       rd    gwe   lwe   sel   csr_rdata     wdata         cwe   cwdata        ec    mr    erf   e_wdata       ecsr  eec   emr
        vecs[0] = '{30'h400, 4'd5, 1'b1, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{30'h401, 4'd7, 1'b1, 1'b0, 1'b1, 32'h00001800, 32'h00000055, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00001800, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{30'h402, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000CAFE, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000CAFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{30'h403, 4'd3, 1'b0, 1'b1, 1'b0, 32'h0,        32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{30'h404, 4'd9, 1'b1, 1'b0, 1'b1, 32'h00000077, 32'h0000BEEF, 1'b1, 32'h0000A5A5, 1'b0, 1'b0, 1'b1, 32'h00000077, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{30'h405, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[6] = '{30'h406, 4'd2, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};
        vecs[7] = '{30'h407, 4'd15, 1'b0, 1'b0, 1'b1, 32'h00000011, 32'h00000022, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h00000011, 1'b0, 1'b0, 1'b0};

        // ---- reset state ----
        rst = 1'b1;
        clr_inputs();
        commit_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        tick();
        rst = 1'b0;
        exp_instret = 64'd0;
        @(negedge clk);
        chk("post_rst_instret", instret, 64'd0);
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_commit_valid", {63'd0, commit_valid}, 64'd0);

        // ---- table-driven single transactions ----
        for (int i = 0; i < 8; i++) begin
            tick();
            commit_ready = 1'b1;
            in_valid     = 1'b1;
            in_pc        = vecs[i].pc;
            in_rd        = vecs[i].rd;
            in_gpr_we    = vecs[i].gpr_we;
            in_load_we   = vecs[i].load_we;
            in_csr_sel   = vecs[i].csr_sel;
            in_csr_rdata = vecs[i].csr_rdata;
            in_wdata     = vecs[i].wdata;
            in_csr_we    = vecs[i].csr_we;
            in_csr_wdata = vecs[i].csr_wdata;
            in_ecall     = vecs[i].ecall;
            in_mret      = vecs[i].mret;
            @(negedge clk);
            // no same-cycle bypass
            chk("vec_no_bypass", {63'd0, commit_valid}, 64'd0);
            tick();
            clr_inputs();
            @(negedge clk);
            chk("vec_commit_valid", {63'd0, commit_valid}, 64'd1);
            chk("vec_commit_pc", {34'd0, commit_pc}, {34'd0, vecs[i].pc});
            chk("vec_rf_we", {63'd0, rf_we}, {63'd0, vecs[i].e_rf_we});
            if (vecs[i].e_rf_we) begin
                chk("vec_rf_waddr", {60'd0, rf_waddr}, {60'd0, vecs[i].rd});
                chk("vec_rf_wdata", {32'd0, rf_wdata}, {32'd0, vecs[i].e_wdata});
            end
            chk("vec_csr_we", {63'd0, csr_we}, {63'd0, vecs[i].e_csr_we});
            if (vecs[i].e_csr_we) begin
                chk("vec_csr_wdata", {32'd0, csr_wdata}, {32'd0, vecs[i].csr_wdata});
            end
            chk("vec_trap_ecall", {63'd0, trap_ecall}, {63'd0, vecs[i].e_ecall});
            chk("vec_trap_mret", {63'd0, trap_mret}, {63'd0, vecs[i].e_mret});
            tick();
            exp_instret = exp_instret + 64'd1;
            @(negedge clk);
            chk("vec_instret", instret, exp_instret);
            chk("vec_drained", {63'd0, commit_valid}, 64'd0);
        end

        // ---- back-pressure: fill to DEPTH, reject a third, drain in order ----
        tick();
        commit_ready = 1'b0;
        push_alu(30'h4, 4'd1, 32'h10);
        tick();
        push_alu(30'h5, 4'd2, 32'h14);
        tick();
        push_alu(30'h6, 4'd3, 32'h18);
        @(negedge clk);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_head_pc", {34'd0, commit_pc}, 64'h4);
        chk("full_rf_we_held", {63'd0, rf_we}, 64'd0);
        tick();
        clr_inputs();
        commit_ready = 1'b1;
        @(negedge clk);
        chk("full_retire_in_ready", {63'd0, in_ready}, 64'd0);
        chk("drain0_pc", {34'd0, commit_pc}, 64'h4);
        chk("drain0_rf_wdata", {32'd0, rf_wdata}, 64'h10);
        tick();
        @(negedge clk);
        chk("drain1_pc", {34'd0, commit_pc}, 64'h5);
        chk("drain1_rf_waddr", {60'd0, rf_waddr}, 64'd2);
        chk("drain1_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        exp_instret = exp_instret + 64'd2;
        @(negedge clk);
        chk("third_rejected", {63'd0, commit_valid}, 64'd0);
        chk("drain_instret", instret, exp_instret);

        // ---- steady stream of 10 from reset: pointer wrap and ordering ----
        do_reset();
        commit_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_alu(30'h100 + 30'(i), 4'd6, 32'h1000 + 32'(i));
            @(negedge clk);
            chk("stream_in_ready", {63'd0, in_ready}, 64'd1);
            if (i > 0) begin
                chk("stream_pc", {34'd0, commit_pc}, 64'h100 + 64'(i - 1));
                chk("stream_rf_wdata", {32'd0, rf_wdata}, 64'h1000 + 64'(i - 1));
            end
            tick();
        end
        clr_inputs();
        @(negedge clk);
        chk("stream_last_pc", {34'd0, commit_pc}, 64'h109);
        tick();
        @(negedge clk);
        chk("stream_instret", instret, 64'd10);
        chk("stream_empty", {63'd0, commit_valid}, 64'd0);
        exp_instret = 64'd10;

        // ---- flush with ecall at head, ALU at tail ----
        commit_ready = 1'b0;
        in_valid = 1'b1;
        in_pc    = 30'h20;
        in_ecall = 1'b1;
        tick();
        clr_inputs();
        push_alu(30'h21, 4'd4, 32'h44);
        tick();
        // flush while also offering a new entry, which must be blocked
        clr_inputs();
        push_alu(30'h22, 4'd8, 32'h88);
        flush = 1'b1;
        commit_ready = 1'b1;
        @(negedge clk);
        chk("flush_trap_ecall", {63'd0, trap_ecall}, 64'd1);
        chk("flush_rf_we", {63'd0, rf_we}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        clr_inputs();
        exp_instret = exp_instret + 64'd1;
        @(negedge clk);
        chk("flush_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("flush_tail_rf_we", {63'd0, rf_we}, 64'd0);
        chk("flush_instret", instret, exp_instret);
        tick();
        @(negedge clk);
        chk("flush_stays_empty", {63'd0, commit_valid}, 64'd0);

        // ---- instret wrap: preload all-ones, one retire wraps to 0 ----
        force dut.instret_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_r;
        chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        push_alu(30'h30, 4'd1, 32'h1);
        tick();
        clr_inputs();
        @(negedge clk);
        chk("wrap_rf_we", {63'd0, rf_we}, 64'd1);
        tick();
        @(negedge clk);
        chk("wrap_instret", instret, 64'd0);

        // ---- reset with two entries queued ----
        commit_ready = 1'b0;
        push_alu(30'h40, 4'd3, 32'h33);
        tick();
        push_alu(30'h41, 4'd4, 32'h44);
        tick();
        clr_inputs();
        rst = 1'b1;
        commit_ready = 1'b1;
        @(negedge clk);
        chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("midrst_commit_valid", {63'd0, commit_valid}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_commit_valid", {63'd0, commit_valid}, 64'd0);
        chk("after_rst_instret", instret, 64'd0);
        chk("after_rst_rf_we", {63'd0, rf_we}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
